// File: rtl/fir_sym_mac.sv
// fir_sym_mac: even-length symmetric FIR with a run-time writable coefficient bank.
// The NTAPS-tap filter is folded onto one pre-adder and one multiply-accumulate.
// Each accepted sample takes NTAPS/2+2 clocks: accept, H accumulate cycles, scale.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   x_in         signed input sample (DATA_W)
//   x_in_valid   x_in is presented
//   x_in_ready   high only while idle; accept = x_in_valid & x_in_ready
//   bypass       sampled at acceptance; 1 = pass the sample through unfiltered
//   coef_we      coefficient write strobe, honoured only while idle
//   coef_addr    coefficient index k, 0..NTAPS/2-1
//   coef_wdata   signed coefficient value (COEF_W, FRAC fractional bits)
//   y_out        signed result, held between pulses
//   y_out_valid  one-cycle pulse when y_out is new
//   y_sat        result was clamped; qualified by y_out_valid
//
// NTAPS must be even and at least 4.
module fir_sym_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 32,
  parameter int FRAC   = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [DATA_W-1:0]          x_in,
  input  logic                              x_in_valid,
  output logic                              x_in_ready,
  input  logic                              bypass,
  input  logic                              coef_we,
  input  logic [$clog2(NTAPS/2)-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0]          coef_wdata,
  output logic signed [DATA_W-1:0]          y_out,
  output logic                              y_out_valid,
  output logic                              y_sat
);

  localparam int H      = NTAPS / 2;
  localparam int KW     = $clog2(H);
  localparam int PW     = $clog2(NTAPS);
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + KW;

  localparam logic [KW-1:0]          K_LAST = KW'(H - 1);
  localparam logic signed [ACC_W:0]  HALF   = (ACC_W+1)'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W:0]  Y_MAX  = ((ACC_W+1)'(1) <<< (DATA_W - 1)) - (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0]  Y_MIN  = -((ACC_W+1)'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  // Round half up: add half an LSB of the output grid, then arithmetic shift.
  function automatic logic signed [ACC_W:0] round_frac(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a) + HALF;
    return t >>> FRAC;
  endfunction

  // Returns {clamped, value} with value clamped to the DATA_W signed range.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W:0] r);
    if (r > Y_MAX)
      return {1'b1, Y_MAX[DATA_W-1:0]};
    else if (r < Y_MIN)
      return {1'b1, Y_MIN[DATA_W-1:0]};
    else
      return {1'b0, r[DATA_W-1:0]};
  endfunction

  state_t                     state_q, state_d;
  logic                       is_idle, accum_en, scale_en;
  logic                       accept, coef_wr;

  logic signed [DATA_W-1:0]   samp_q [NTAPS];
  logic signed [COEF_W-1:0]   coef_q [H];
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [KW-1:0]              k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       byp_q, byp_d;
  logic signed [DATA_W-1:0]   x_hold_q;
  logic signed [DATA_W-1:0]   y_out_q, y_out_d;
  logic                       y_vld_q, y_vld_d;
  logic                       y_sat_q, y_sat_d;

  logic [PW:0]                sum_new, sum_old;
  logic [PW-1:0]              idx_new, idx_old;
  logic signed [DATA_W-1:0]   samp_new, samp_old;
  logic signed [PRE_W-1:0]    pre_add;
  logic signed [PROD_W-1:0]   product;

  // ---- control: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (x_in_valid) state_d = ACCUM;
      ACCUM:   if (k_q == K_LAST) state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_idle  = (state_q == IDLE);
    accum_en = (state_q == ACCUM);
    scale_en = (state_q == SCALE);
  end

  assign accept  = x_in_valid & is_idle;
  assign coef_wr = coef_we & is_idle & (int'(coef_addr) < H);

  // ---- accumulate stage: fold s[k] and s[NTAPS-1-k] through the pre-adder ----
  // wptr_q points one past the newest sample, so s[j] lives at wptr-1-j (mod NTAPS)
  // and s[NTAPS-1-k] lives at wptr+k (mod NTAPS).
  always_comb begin
    sum_new = {1'b0, wptr_q} + (PW+1)'(NTAPS - 1) - (PW+1)'(k_q);
    sum_old = {1'b0, wptr_q} + (PW+1)'(k_q);
    idx_new = (int'(sum_new) >= NTAPS) ? PW'(sum_new - (PW+1)'(NTAPS)) : PW'(sum_new);
    idx_old = (int'(sum_old) >= NTAPS) ? PW'(sum_old - (PW+1)'(NTAPS)) : PW'(sum_old);
    samp_new = samp_q[idx_new];
    samp_old = samp_q[idx_old];
    pre_add  = PRE_W'(samp_new) + PRE_W'(samp_old);
    product  = PROD_W'(pre_add) * PROD_W'(coef_q[k_q]);
  end

  always_comb begin
    wptr_d = wptr_q;
    k_d    = k_q;
    acc_d  = acc_q;
    byp_d  = byp_q;
    if (accept) begin
      wptr_d = (int'(wptr_q) == NTAPS - 1) ? '0 : wptr_q + PW'(1);
      k_d    = '0;
      acc_d  = '0;
      byp_d  = bypass;
    end else if (accum_en) begin
      k_d   = k_q + KW'(1);
      acc_d = acc_q + ACC_W'(product);
    end
  end

  // ---- scale stage: round, clamp and register the result ----
  always_comb begin
    y_out_d = y_out_q;
    y_sat_d = y_sat_q;
    y_vld_d = 1'b0;
    if (scale_en) begin
      y_vld_d = 1'b1;
      if (byp_q) begin
        y_out_d = x_hold_q;
        y_sat_d = 1'b0;
      end else begin
        {y_sat_d, y_out_d} = saturate(round_frac(acc_q));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      byp_q   <= 1'b0;
      y_out_q <= '0;
      y_vld_q <= 1'b0;
      y_sat_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      byp_q   <= byp_d;
      y_out_q <= y_out_d;
      y_vld_q <= y_vld_d;
      y_sat_q <= y_sat_d;
    end
  end

  // Sample history and coefficient bank both restart from zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) samp_q[i] <= '0;
      for (int i = 0; i < H; i++)     coef_q[i] <= '0;
    end else begin
      if (accept)  samp_q[wptr_q]    <= x_in;
      if (coef_wr) coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Copy of the accepted sample for the bypass path.
  always_ff @(posedge clk) begin
    if (accept) x_hold_q <= x_in;
  end

  assign x_in_ready  = is_idle;
  assign y_out       = y_out_q;
  assign y_out_valid = y_vld_q;
  assign y_sat       = y_sat_q;

endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac: randomized self-checking bench for fir_sym_mac at default parameters.
// A reference model keeps the sample history and coefficients as plain arrays and
// computes each expected output directly from the filter equation.
module tb_fir_sym_mac;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 32;
  localparam int FRAC   = 15;
  localparam int H      = NTAPS / 2;
  localparam int KW     = $clog2(H);

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic signed [DATA_W-1:0] x_in = '0;
  logic                     x_in_valid = 1'b0;
  logic                     x_in_ready;
  logic                     bypass = 1'b0;
  logic                     coef_we = 1'b0;
  logic [KW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic signed [DATA_W-1:0] y_out;
  logic                     y_out_valid;
  logic                     y_sat;

  fir_sym_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset),
    .x_in(x_in), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready),
    .bypass(bypass),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .y_out(y_out), .y_out_valid(y_out_valid), .y_sat(y_sat)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model.
  typedef struct { longint y; bit sat; int cyc; } exp_t;
  exp_t   exp_q[$];
  longint hist[NTAPS];
  longint coef_m[H];

  function automatic void model_reset();
    for (int j = 0; j < NTAPS; j++) hist[j] = 0;
    for (int k = 0; k < H; k++) coef_m[k] = 0;
    exp_q.delete();
  endfunction

  // Called at the falling edge before the accepting rising edge.
  function automatic void model_accept(input longint x, input bit byp);
    exp_t   e;
    longint acc, r, ymax, ymin;
    ymax = (64'sd1 <<< (DATA_W - 1)) - 1;
    ymin = -(64'sd1 <<< (DATA_W - 1));
    for (int j = NTAPS - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = x;
    if (byp) begin
      e.y = x;
      e.sat = 1'b0;
    end else begin
      acc = 0;
      for (int k = 0; k < H; k++) acc += (hist[k] + hist[NTAPS-1-k]) * coef_m[k];
      r = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      if (r > ymax)      begin e.y = ymax; e.sat = 1'b1; end
      else if (r < ymin) begin e.y = ymin; e.sat = 1'b1; end
      else               begin e.y = r;    e.sat = 1'b0; end
    end
    e.cyc = cyc_cnt + 1;
    exp_q.push_back(e);
  endfunction

  // Output monitor: every pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (y_out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_vld", y_out_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("y_out", y_out, mon_e.y);
        check_val("y_sat", y_sat, mon_e.sat);
        check_val("latency", cyc_cnt - mon_e.cyc, H + 1);
        check_val("rdy_at_vld", x_in_ready, 1);
      end
    end
  end

  task automatic coef_write(input int k, input longint v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = k[KW-1:0];
    coef_wdata = v[COEF_W-1:0];
    if (x_in_ready) coef_m[k] = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic accept(input longint x, input bit byp,
                        input bit we = 1'b0, input int k = 0, input longint v = 0);
    int g = 0;
    @(negedge clk);
    while (!x_in_ready && g < 100) begin @(negedge clk); g++; end
    if (!x_in_ready) begin
      check_val("rdy_timeout", x_in_ready, 1);
    end else begin
      x_in = x[DATA_W-1:0];
      bypass = byp;
      x_in_valid = 1'b1;
      if (we) begin
        coef_we = 1'b1;
        coef_addr = k[KW-1:0];
        coef_wdata = v[COEF_W-1:0];
        coef_m[k] = v;
      end
      model_accept(x, byp);
      @(negedge clk);
      x_in_valid = 1'b0;
      coef_we = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin @(posedge clk); g++; end
    @(posedge clk);
    #2;
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic load_ramp_coefs();
    for (int k = 0; k < H; k++) coef_write(k, k + 1);
  endtask

  initial begin
    longint xr;
    bit     b;
    int     n, last, guard;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_y_out", y_out, 0);
    check_val("rst_vld", y_out_valid, 0);
    check_val("rst_sat", y_sat, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_rdy", x_in_ready, 1);

    // Impulse response with ramp coefficients.
    load_ramp_coefs();
    accept(32767, 1'b0);
    for (int i = 0; i < 40; i++) accept(0, 1'b0);
    wait_drain();

    // Random coefficients, samples, bypass and same-cycle coefficient writes.
    for (int k = 0; k < H; k++) coef_write(k, longint'($urandom_range(4096)) - 2048);
    for (int i = 0; i < 24; i++) begin
      xr = longint'($urandom_range(65535)) - 32768;
      b  = ($urandom_range(5) == 0);
      if (i % 4 == 1)
        accept(xr, b, 1'b1, int'($urandom_range(H - 1)), longint'($urandom_range(4096)) - 2048);
      else
        accept(xr, b);
    end
    wait_drain();

    // Back-to-back: valid held high, acceptances must be H+2 clocks apart.
    n = 0; last = -1; guard = 0;
    bypass = 1'b0;
    x_in = DATA_W'($urandom_range(65535));
    x_in_valid = 1'b1;
    while (n < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (x_in_ready) begin
        model_accept(x_in, 1'b0);
        if (last >= 0) check_val("spacing", cyc_cnt + 1 - last, H + 2);
        last = cyc_cnt + 1;
        n++;
        @(posedge clk);
        #1;
        x_in = DATA_W'($urandom_range(65535));
        if (n == 4) x_in_valid = 1'b0;
      end
    end
    x_in_valid = 1'b0;
    check_val("cont_count", n, 4);
    wait_drain();

    // Saturation at both rails.
    for (int k = 0; k < H; k++) coef_write(k, 16384);
    for (int i = 0; i < NTAPS; i++) accept(32767, 1'b0);
    for (int i = 0; i < NTAPS; i++) accept(-32768, 1'b0);
    wait_drain();

    // Reset in the middle of an accumulation.
    accept(12345, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("mid_rst_y_out", y_out, 0);
    check_val("mid_rst_vld", y_out_valid, 0);
    check_val("mid_rst_sat", y_sat, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_rst_rdy", x_in_ready, 1);
    repeat (25) @(posedge clk);
    load_ramp_coefs();
    accept(32767, 1'b0);
    for (int i = 0; i < 33; i++) accept(0, 1'b0);
    wait_drain();

    // Coefficient write during accumulation must be dropped.
    accept(32767, 1'b0);
    repeat (3) @(posedge clk);
    coef_write(0, 1000);
    for (int i = 0; i < 32; i++) accept(0, 1'b0);
    wait_drain();

    // Bypass.
    accept(-1234, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
